// File: rtl/fwupd_pkg.sv
// Shared definitions for the firmware-update URAM bank address generator.
//   FWUPD_NBANKS_DEF / FWUPD_DEPTH_DEF : default bank count and words per bank
//   ERR_WR_OVF / ERR_RD_UNF            : bit positions inside err_o
//   fwupd_uaddr_t                      : {bank, word} address at default sizes
package fwupd_pkg;

   localparam int FWUPD_NBANKS_DEF = 2;
   localparam int FWUPD_DEPTH_DEF  = 128;

   localparam int ERR_WR_OVF = 0;
   localparam int ERR_RD_UNF = 1;

   typedef logic [$clog2(FWUPD_NBANKS_DEF)+$clog2(FWUPD_DEPTH_DEF)-1:0] fwupd_uaddr_t;

endpackage

// File: rtl/fwupd_word_cnt.sv
// Word pointer inside the current write bank.
//   i_clk, i_rstb : clock, asynchronous active-low reset
//   i_clr         : synchronous return to word 0 (wins over i_ce)
//   i_ce          : advance by one; ignored at terminal count (holds)
//   o_word        : current word index
//   o_tc          : o_word == DEPTH-1
module fwupd_word_cnt #(
   parameter  int DEPTH  = 128,
   localparam int WORD_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rstb,
   input  logic              i_clr,
   input  logic              i_ce,
   output logic [WORD_W-1:0] o_word,
   output logic              o_tc
);

   logic [WORD_W-1:0] r_word;

   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb)
         r_word <= '0;
      else if (i_clr)
         r_word <= '0;
      else if (i_ce && !o_tc)
         r_word <= r_word + WORD_W'(1);
   end

   assign o_word = r_word;
   assign o_tc   = (r_word == WORD_W'(DEPTH-1));

endmodule

// File: rtl/fwupd_bank_addr.sv
// N-bank URAM address generator for the firmware-update path.
// The writer fills the current bank and marks it complete; the reader drains
// complete banks in ring order and releases them.
//   clk_i, rstb_i : clock, asynchronous active-low reset
//   flush_i       : synchronous clear of all bank state (errors kept)
//   ce_i, mark_i  : write strobe at uaddr_o / mark current write bank complete
//   wr_ready_o    : current write bank is not full
//   uaddr_o       : write address {wr_bank, word}
//   rd_done_i     : reader releases rd_bank_o
//   rd_valid_o, rd_bank_o, rd_len_o : oldest full bank and its fill length
//   bank_full_o   : per-bank full flags
//   err_o, err_clr_i : sticky {read underflow, write overflow} and its clear
module fwupd_bank_addr
   import fwupd_pkg::*;
#(
   parameter  int NBANKS    = FWUPD_NBANKS_DEF,
   parameter  int DEPTH     = FWUPD_DEPTH_DEF,
   parameter  int AUTO_MARK = 0,
   localparam int BANK_W    = $clog2(NBANKS),
   localparam int WORD_W    = $clog2(DEPTH),
   localparam int LEN_W     = WORD_W + 1
) (
   input  logic                     clk_i,
   input  logic                     rstb_i,
   input  logic                     flush_i,
   input  logic                     ce_i,
   input  logic                     mark_i,
   output logic                     wr_ready_o,
   output logic [BANK_W+WORD_W-1:0] uaddr_o,
   input  logic                     rd_done_i,
   output logic                     rd_valid_o,
   output logic [BANK_W-1:0]        rd_bank_o,
   output logic [LEN_W-1:0]         rd_len_o,
   output logic [NBANKS-1:0]        bank_full_o,
   output logic [1:0]               err_o,
   input  logic                     err_clr_i
);

   logic [BANK_W-1:0]             r_wr_bank;
   logic [BANK_W-1:0]             r_rd_bank;
   logic [NBANKS-1:0]             r_full;
   logic [NBANKS-1:0][LEN_W-1:0]  r_len;
   logic [1:0]                    r_err;

   logic [WORD_W-1:0] w_word;
   logic              w_tc;
   logic              w_wr_ready, w_rd_valid;
   logic              w_ce_ok, w_mark_ok, w_auto, w_mark, w_rd_ok;
   logic              w_wr_ovf, w_rd_unf;
   logic [LEN_W-1:0]  w_new_len;

   assign w_wr_ready = ~r_full[r_wr_bank];
   assign w_rd_valid =  r_full[r_rd_bank];

   // flush overrides every other request, including their error side effects
   assign w_ce_ok   = ce_i & w_wr_ready & ~flush_i;
   assign w_mark_ok = mark_i & w_wr_ready & ~flush_i;
   assign w_auto    = (AUTO_MARK != 0) & w_ce_ok & w_tc;
   assign w_mark    = w_mark_ok | w_auto;   // implicit + explicit = one mark
   assign w_rd_ok   = rd_done_i & w_rd_valid & ~flush_i;

   // Overflow: request to a full bank, or a write past the last word that is
   // not closed by a mark in the same cycle (that write lands and is counted).
   assign w_wr_ovf = ~flush_i & (((ce_i | mark_i) & ~w_wr_ready) |
                                 (w_ce_ok & w_tc & ~w_mark));
   assign w_rd_unf = ~flush_i & rd_done_i & ~w_rd_valid;

   // A write in the marking cycle is counted in the bank length
   assign w_new_len = LEN_W'(w_word) + LEN_W'(w_ce_ok);

   fwupd_word_cnt #(.DEPTH(DEPTH)) u_word_cnt (
      .i_clk  (clk_i),
      .i_rstb (rstb_i),
      .i_clr  (flush_i | w_mark),
      .i_ce   (w_ce_ok),
      .o_word (w_word),
      .o_tc   (w_tc)
   );

   // mark acts on wr_bank, rd_done on rd_bank; marking needs !full[wr_bank]
   // while releasing needs full[rd_bank], so the two never hit the same bank.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         r_wr_bank <= '0;
         r_rd_bank <= '0;
         r_full    <= '0;
         r_len     <= '0;
      end else if (flush_i) begin
         r_wr_bank <= '0;
         r_rd_bank <= '0;
         r_full    <= '0;
         r_len     <= '0;
      end else begin
         if (w_mark) begin
            r_full[r_wr_bank] <= 1'b1;
            r_len[r_wr_bank]  <= w_new_len;
            r_wr_bank         <= r_wr_bank + BANK_W'(1);
         end
         if (w_rd_ok) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= r_rd_bank + BANK_W'(1);
         end
      end
   end

   // A new error event beats a simultaneous clear
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i)
         r_err <= '0;
      else begin
         r_err             <= r_err & {2{~err_clr_i}};
         if (w_wr_ovf) r_err[ERR_WR_OVF] <= 1'b1;
         if (w_rd_unf) r_err[ERR_RD_UNF] <= 1'b1;
      end
   end

   assign wr_ready_o  = w_wr_ready;
   assign uaddr_o     = {r_wr_bank, w_word};
   assign rd_valid_o  = w_rd_valid;
   assign rd_bank_o   = r_rd_bank;
   assign rd_len_o    = r_len[r_rd_bank];
   assign bank_full_o = r_full;
   assign err_o       = r_err;

endmodule

// File: tb/tb_fwupd_bank_addr.sv
module tb_fwupd_bank_addr;

   logic       clk_i = 1'b0;
   logic       rstb_i = 1'b0;
   logic       flush_i = 1'b0, ce_i = 1'b0, mark_i = 1'b0;
   logic       rd_done_i = 1'b0, err_clr_i = 1'b0;

   // dut: NBANKS=4 DEPTH=8 AUTO_MARK=0
   logic       wr_ready_o, rd_valid_o;
   logic [4:0] uaddr_o;
   logic [1:0] rd_bank_o, err_o;
   logic [3:0] rd_len_o, bank_full_o;

   // dut_am: same sizes, AUTO_MARK=1, same inputs
   logic       am_wr_ready, am_rd_valid;
   logic [4:0] am_uaddr;
   logic [1:0] am_rd_bank, am_err;
   logic [3:0] am_rd_len, am_full;

   int n_pass = 0, n_tot = 0;

   always #5 clk_i = ~clk_i;

   fwupd_bank_addr #(.NBANKS(4), .DEPTH(8), .AUTO_MARK(0)) dut (
      .clk_i(clk_i), .rstb_i(rstb_i), .flush_i(flush_i), .ce_i(ce_i), .mark_i(mark_i),
      .wr_ready_o(wr_ready_o), .uaddr_o(uaddr_o), .rd_done_i(rd_done_i),
      .rd_valid_o(rd_valid_o), .rd_bank_o(rd_bank_o), .rd_len_o(rd_len_o),
      .bank_full_o(bank_full_o), .err_o(err_o), .err_clr_i(err_clr_i));

   fwupd_bank_addr #(.NBANKS(4), .DEPTH(8), .AUTO_MARK(1)) dut_am (
      .clk_i(clk_i), .rstb_i(rstb_i), .flush_i(flush_i), .ce_i(ce_i), .mark_i(mark_i),
      .wr_ready_o(am_wr_ready), .uaddr_o(am_uaddr), .rd_done_i(rd_done_i),
      .rd_valid_o(am_rd_valid), .rd_bank_o(am_rd_bank), .rd_len_o(am_rd_len),
      .bank_full_o(am_full), .err_o(am_err), .err_clr_i(err_clr_i));

   // one clock with the given inputs; returns 1 ns after the edge
   task automatic step(input logic ce, input logic mk, input logic rd,
                       input logic fl, input logic ec);
      ce_i = ce; mark_i = mk; rd_done_i = rd; flush_i = fl; err_clr_i = ec;
      @(posedge clk_i); #1;
      ce_i = 0; mark_i = 0; rd_done_i = 0; flush_i = 0; err_clr_i = 0;
   endtask

   task automatic do_reset();
      rstb_i = 1'b0;
      @(posedge clk_i); #1;
      rstb_i = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tot++; if (uaddr_o !== 5'd0) $display("FAIL reset_uaddr got=%0d exp=0", uaddr_o); else n_pass++;
      n_tot++; if (wr_ready_o !== 1'b1) $display("FAIL reset_wr_ready got=%b exp=1", wr_ready_o); else n_pass++;
      n_tot++; if (rd_valid_o !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid_o); else n_pass++;
      n_tot++; if (rd_bank_o !== 2'd0) $display("FAIL reset_rd_bank got=%0d exp=0", rd_bank_o); else n_pass++;
      n_tot++; if (rd_len_o !== 4'd0) $display("FAIL reset_rd_len got=%0d exp=0", rd_len_o); else n_pass++;
      n_tot++; if (bank_full_o !== 4'h0) $display("FAIL reset_full got=%h exp=0", bank_full_o); else n_pass++;
      n_tot++; if (err_o !== 2'b00) $display("FAIL reset_err got=%b exp=00", err_o); else n_pass++;
   endtask

   task automatic test_basic();
      logic [4:0] exp_a [3];
      exp_a = '{5'd0, 5'd1, 5'd2};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         n_tot++; if (uaddr_o !== exp_a[i]) $display("FAIL basic_uaddr%0d got=%0d exp=%0d", i, uaddr_o, exp_a[i]); else n_pass++;
         step(1, 0, 0, 0, 0);
      end
      step(0, 1, 0, 0, 0);
      n_tot++; if (uaddr_o !== 5'd8) $display("FAIL basic_mark_uaddr got=%0d exp=8", uaddr_o); else n_pass++;
      n_tot++; if (rd_valid_o !== 1'b1) $display("FAIL basic_rd_valid got=%b exp=1", rd_valid_o); else n_pass++;
      n_tot++; if (rd_bank_o !== 2'd0) $display("FAIL basic_rd_bank got=%0d exp=0", rd_bank_o); else n_pass++;
      n_tot++; if (rd_len_o !== 4'd3) $display("FAIL basic_rd_len got=%0d exp=3", rd_len_o); else n_pass++;
      n_tot++; if (bank_full_o !== 4'h1) $display("FAIL basic_full got=%h exp=1", bank_full_o); else n_pass++;
      step(0, 0, 1, 0, 0);
      n_tot++; if (rd_valid_o !== 1'b0) $display("FAIL basic_release_valid got=%b exp=0", rd_valid_o); else n_pass++;
      n_tot++; if (rd_bank_o !== 2'd1) $display("FAIL basic_release_bank got=%0d exp=1", rd_bank_o); else n_pass++;
   endtask

   task automatic test_full();
      do_reset();
      for (int b = 0; b < 4; b++) begin
         step(1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0);
         step(0, 1, 0, 0, 0);
      end
      n_tot++; if (wr_ready_o !== 1'b0) $display("FAIL full_wr_ready got=%b exp=0", wr_ready_o); else n_pass++;
      n_tot++; if (bank_full_o !== 4'hF) $display("FAIL full_flags got=%h exp=f", bank_full_o); else n_pass++;
      n_tot++; if (uaddr_o !== 5'd0) $display("FAIL full_uaddr got=%0d exp=0", uaddr_o); else n_pass++;
      step(1, 0, 0, 0, 0);
      n_tot++; if (err_o !== 2'b01) $display("FAIL full_ovf_err got=%b exp=01", err_o); else n_pass++;
      n_tot++; if (uaddr_o !== 5'd0) $display("FAIL full_ovf_uaddr got=%0d exp=0", uaddr_o); else n_pass++;
      step(0, 0, 1, 0, 0);
      n_tot++; if (wr_ready_o !== 1'b1) $display("FAIL full_free_ready got=%b exp=1", wr_ready_o); else n_pass++;
      n_tot++; if (rd_bank_o !== 2'd1) $display("FAIL full_free_rd_bank got=%0d exp=1", rd_bank_o); else n_pass++;
      n_tot++; if (bank_full_o !== 4'hE) $display("FAIL full_free_flags got=%h exp=e", bank_full_o); else n_pass++;
      n_tot++; if (rd_len_o !== 4'd2) $display("FAIL full_free_len got=%0d exp=2", rd_len_o); else n_pass++;
   endtask

   task automatic test_auto_mark();
      do_reset();
      for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
      n_tot++; if (uaddr_o !== 5'd7) $display("FAIL auto_last_uaddr got=%0d exp=7", uaddr_o); else n_pass++;
      n_tot++; if (err_o !== 2'b00) $display("FAIL auto_last_err got=%b exp=00", err_o); else n_pass++;
      step(1, 0, 0, 0, 0);
      n_tot++; if (am_uaddr !== 5'd8) $display("FAIL am_uaddr got=%0d exp=8", am_uaddr); else n_pass++;
      n_tot++; if (am_full !== 4'h1) $display("FAIL am_full got=%h exp=1", am_full); else n_pass++;
      n_tot++; if (am_rd_len !== 4'd8) $display("FAIL am_rd_len got=%0d exp=8", am_rd_len); else n_pass++;
      n_tot++; if (am_err !== 2'b00) $display("FAIL am_err got=%b exp=00", am_err); else n_pass++;
      step(1, 0, 0, 0, 0);
      n_tot++; if (uaddr_o !== 5'd7) $display("FAIL noauto_hold_uaddr got=%0d exp=7", uaddr_o); else n_pass++;
      n_tot++; if (err_o !== 2'b01) $display("FAIL noauto_ovf_err got=%b exp=01", err_o); else n_pass++;
      n_tot++; if (bank_full_o !== 4'h0) $display("FAIL noauto_full got=%h exp=0", bank_full_o); else n_pass++;
      n_tot++; if (am_uaddr !== 5'd9) $display("FAIL am_next_uaddr got=%0d exp=9", am_uaddr); else n_pass++;
   endtask

   task automatic test_ce_mark();
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
      n_tot++; if (uaddr_o !== 5'd5) $display("FAIL cm_pre_uaddr got=%0d exp=5", uaddr_o); else n_pass++;
      step(1, 1, 0, 0, 0);
      n_tot++; if (rd_len_o !== 4'd6) $display("FAIL cm_len got=%0d exp=6", rd_len_o); else n_pass++;
      n_tot++; if (uaddr_o !== 5'd8) $display("FAIL cm_uaddr got=%0d exp=8", uaddr_o); else n_pass++;
      step(0, 1, 1, 0, 0);
      n_tot++; if (bank_full_o !== 4'h2) $display("FAIL mr_full got=%h exp=2", bank_full_o); else n_pass++;
      n_tot++; if (rd_bank_o !== 2'd1) $display("FAIL mr_rd_bank got=%0d exp=1", rd_bank_o); else n_pass++;
      n_tot++; if (rd_len_o !== 4'd0) $display("FAIL mr_empty_len got=%0d exp=0", rd_len_o); else n_pass++;
      n_tot++; if (uaddr_o !== 5'd16) $display("FAIL mr_uaddr got=%0d exp=16", uaddr_o); else n_pass++;
      n_tot++; if (err_o !== 2'b00) $display("FAIL mr_err got=%b exp=00", err_o); else n_pass++;
   endtask

   task automatic test_err();
      do_reset();
      step(0, 0, 1, 0, 0);
      n_tot++; if (err_o !== 2'b10) $display("FAIL err_unf got=%b exp=10", err_o); else n_pass++;
      n_tot++; if (rd_bank_o !== 2'd0) $display("FAIL err_unf_bank got=%0d exp=0", rd_bank_o); else n_pass++;
      step(0, 0, 0, 0, 1);
      n_tot++; if (err_o !== 2'b00) $display("FAIL err_clr got=%b exp=00", err_o); else n_pass++;
      step(0, 0, 1, 0, 1);
      n_tot++; if (err_o !== 2'b10) $display("FAIL err_clr_vs_set got=%b exp=10", err_o); else n_pass++;
      step(0, 0, 0, 0, 1);
      n_tot++; if (err_o !== 2'b00) $display("FAIL err_clr2 got=%b exp=00", err_o); else n_pass++;
   endtask

   task automatic build_mid_bank();
      step(0, 0, 1, 0, 0);            // leaves err_o = 10
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic test_reset_flush();
      do_reset();
      build_mid_bank();
      n_tot++; if (uaddr_o !== 5'd21) $display("FAIL mid_uaddr got=%0d exp=21", uaddr_o); else n_pass++;
      n_tot++; if (bank_full_o !== 4'h3) $display("FAIL mid_full got=%h exp=3", bank_full_o); else n_pass++;
      #2 rstb_i = 1'b0;               // mid-cycle, no clock edge
      #1;
      n_tot++; if (uaddr_o !== 5'd0) $display("FAIL arst_uaddr got=%0d exp=0", uaddr_o); else n_pass++;
      n_tot++; if (bank_full_o !== 4'h0) $display("FAIL arst_full got=%h exp=0", bank_full_o); else n_pass++;
      n_tot++; if (wr_ready_o !== 1'b1) $display("FAIL arst_ready got=%b exp=1", wr_ready_o); else n_pass++;
      n_tot++; if (rd_valid_o !== 1'b0) $display("FAIL arst_valid got=%b exp=0", rd_valid_o); else n_pass++;
      n_tot++; if (err_o !== 2'b00) $display("FAIL arst_err got=%b exp=00", err_o); else n_pass++;
      rstb_i = 1'b1;
      @(posedge clk_i); #1;
      build_mid_bank();
      step(1, 0, 0, 1, 0);            // flush beats the write
      n_tot++; if (uaddr_o !== 5'd0) $display("FAIL flush_uaddr got=%0d exp=0", uaddr_o); else n_pass++;
      n_tot++; if (bank_full_o !== 4'h0) $display("FAIL flush_full got=%h exp=0", bank_full_o); else n_pass++;
      n_tot++; if (rd_valid_o !== 1'b0) $display("FAIL flush_valid got=%b exp=0", rd_valid_o); else n_pass++;
      n_tot++; if (rd_len_o !== 4'd0) $display("FAIL flush_len got=%0d exp=0", rd_len_o); else n_pass++;
      n_tot++; if (err_o !== 2'b10) $display("FAIL flush_err_kept got=%b exp=10", err_o); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_auto_mark();
      test_ce_mark();
      test_err();
      test_reset_flush();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
